cic_out_rr_mux: RTL

//  Round-robin scheduler sharing one downstream sample stream between NCH str_cic_downsampler outputs.

---
 rtl/cic_daq_pkg.sv | 39 +++
 rtl/cic_out_rr_mux_rr_arbiter.sv | 49 ++++
 rtl/cic_out_rr_mux.sv | 111 +++++++++++
 3 files changed

// File: rtl/cic_daq_pkg.sv
// Shared types and the round-robin search helper for the CIC output mux.
// Types are sized for the widest supported configuration (16 channels);
// each module narrows them to its own channel count.
package cic_daq_pkg;

  localparam int unsigned NCH_MAX = 16;
  localparam int unsigned CHW_MAX = 4;

  typedef logic [CHW_MAX-1:0] chan_id_t;

  // Result of one round-robin search.
  typedef struct packed {
    logic     found;
    chan_id_t idx;
  } pick_t;

  // First asserted request after ptr, wrapping modulo nch.
  // The search starts at ptr+1 and ends at ptr itself, so the channel that
  // won last time has the lowest priority this time.
  function automatic pick_t rr_pick(input logic [NCH_MAX-1:0] req,
                                    input chan_id_t ptr,
                                    input int unsigned nch);
    pick_t       r;
    int unsigned c;
    r.found = 1'b0;
    r.idx   = '0;
    for (int unsigned k = 1; k <= NCH_MAX; k++) begin
      // ptr < nch and k <= nch, so one wrap subtraction is enough.
      c = 32'(ptr) + k;
      if (c >= nch) c = c - nch;
      if (k <= nch && !r.found && req[c[CHW_MAX-1:0]]) begin
        r.found = 1'b1;
        r.idx   = c[CHW_MAX-1:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/cic_out_rr_mux_rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus index, owns the priority pointer.
// The pointer moves to the winner only when the grant is actually taken.
module rr_arbiter
  import cic_daq_pkg::*;
#(
  parameter int unsigned NCH = 4,
  parameter int unsigned CHW = $clog2(NCH)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [NCH-1:0] req,
  input  logic           advance,
  output logic [NCH-1:0] grant,
  output logic [CHW-1:0] grant_idx,
  output logic           grant_valid,
  output logic [CHW-1:0] ptr
);

  logic [NCH_MAX-1:0] req_ext;
  chan_id_t           ptr_ext;
  pick_t              pick;
  logic               unused_pick_bits;

  // Pointer register: reset to the last channel so channel 0 wins first.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= CHW'(NCH - 1);
    end else if (advance) begin
      ptr <= grant_idx;
    end
  end

  // Widen to the package search width, pick a winner, decode to one-hot.
  always_comb begin
    req_ext            = '0;
    req_ext[NCH-1:0]   = req;
    ptr_ext            = '0;
    ptr_ext[CHW-1:0]   = ptr;
    pick               = rr_pick(req_ext, ptr_ext, NCH);
    grant_valid        = pick.found;
    grant_idx          = pick.idx[CHW-1:0];
    grant              = '0;
    if (pick.found) grant[grant_idx] = 1'b1;
  end

  // Upper index bits are always zero for small channel counts.
  assign unused_pick_bits = &{1'b0, pick};

endmodule

// File: rtl/cic_out_rr_mux.sv
// Round-robin mux sharing one output stream between NCH CIC channels.
// Enabled channels are arbitrated and the winner is registered with its tag;
// disabled channels are always drained and counted in drop_cnt.
//
// Handshake: every stream transfers on a rising edge where valid and ready
// are both high. Ready may depend combinationally on valid (in_ready[i]
// follows the arbitration of in_valid), valid never depends on ready, and
// out_data/out_chan stay frozen while out_valid is high and out_ready is low.
module cic_out_rr_mux
  import cic_daq_pkg::*;
#(
  parameter int unsigned DW   = 32,
  parameter int unsigned NCH  = 4,
  parameter int unsigned CNTW = 16,
  parameter int unsigned CHW  = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH-1:0]    chan_en,
  input  logic [NCH*DW-1:0] in_data,
  input  logic [NCH-1:0]    in_valid,
  output logic [NCH-1:0]    in_ready,
  output logic [DW-1:0]     out_data,
  output logic [CHW-1:0]    out_chan,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNTW-1:0]   drop_cnt
);

  localparam logic [CNTW+4:0] CNT_MAX = {5'b0, {CNTW{1'b1}}};

  logic           load_en;
  logic [NCH-1:0] req;
  logic [NCH-1:0] grant;
  logic [CHW-1:0] grant_idx;
  logic           grant_valid;
  logic           take;
  logic [CHW-1:0] rr_ptr;
  logic           unused_rr_ptr;

  logic [NCH-1:0]  drop_req;
  logic [4:0]      drop_pc;
  logic [CNTW+4:0] drop_sum;
  logic [CNTW-1:0] drop_next;

  // The output register can accept a new sample when it is empty or draining.
  assign load_en = !out_valid || out_ready;
  assign req     = in_valid & chan_en;
  assign take    = grant_valid && load_en && rst_n;

  rr_arbiter #(
    .NCH (NCH),
    .CHW (CHW)
  ) u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .advance     (take),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .ptr         (rr_ptr)
  );

  // The pointer is kept visible for probing inside the arbiter instance.
  assign unused_rr_ptr = ^rr_ptr;

  // Ready: the granted channel when the register can load, plus every
  // disabled channel (drained unconditionally); nothing while in reset.
  always_comb begin
    in_ready = ((grant & {NCH{load_en}}) | ~chan_en) & {NCH{rst_n}};
  end

  // Output register: load the winner, clear valid when drained with no winner.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
    end else if (load_en) begin
      if (grant_valid) begin
        out_valid <= 1'b1;
        out_data  <= in_data[grant_idx*DW +: DW];
        out_chan  <= grant_idx;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

  // Count samples accepted from disabled channels this cycle, saturating.
  always_comb begin
    drop_req = in_valid & ~chan_en & {NCH{rst_n}};
    drop_pc  = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      drop_pc = drop_pc + {4'b0, drop_req[i]};
    end
    drop_sum  = {5'b0, drop_cnt} + {{CNTW{1'b0}}, drop_pc};
    drop_next = (drop_sum > CNT_MAX) ? {CNTW{1'b1}} : drop_sum[CNTW-1:0];
  end

  // Drop counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else begin
      drop_cnt <= drop_next;
    end
  end

endmodule
